bsg_demux_one_hot_buffered: RTL

//  Steers one input word to one of els_p output lanes, chosen by a one-hot select.

---
 rtl/bsg_demux_one_hot_pkg.sv | 18 +
 rtl/bsg_demux_one_hot_buffered_if.sv | 29 ++
 rtl/bsg_demux_one_hot_slot.sv | 35 +++
 rtl/bsg_demux_one_hot_buffered.sv | 72 +++++++
 4 files changed

// File: rtl/bsg_demux_one_hot_pkg.sv
// Shared constants and select-decode helper for the buffered one-hot demux.
package bsg_demux_one_hot_pkg;

   localparam int width_default_lp = 9;
   localparam int els_default_lp   = 5;
   localparam int sel_max_lp       = 64;

   // True when exactly one bit of the (zero-extended) select vector is set.
   function automatic logic is_one_hot(input logic [sel_max_lp-1:0] vec);
      int unsigned ones_s;
      ones_s = 32'd0;
      for (int i = 0; i < sel_max_lp; i++) begin
         ones_s = ones_s + 32'(vec[i]);
      end
      return (ones_s == 32'd1);
   endfunction

endpackage

// File: rtl/bsg_demux_one_hot_buffered_if.sv
// Producer/consumer bundle for bsg_demux_one_hot_buffered.
// err_o exists only when BSG_DEMUX_ONE_HOT_SEL_CHECK_EN is defined.
interface bsg_demux_one_hot_buffered_if
   import bsg_demux_one_hot_pkg::*;
#(
   parameter int width_p = width_default_lp,
   parameter int els_p   = els_default_lp
);
   logic                     v_i;
   logic [width_p-1:0]       data_i;
   logic [els_p-1:0]         sel_one_hot_i;
   logic                     ready_o;
   logic [els_p-1:0]         v_o;
   logic [els_p*width_p-1:0] data_o;
   logic [els_p-1:0]         yumi_i;
`ifdef BSG_DEMUX_ONE_HOT_SEL_CHECK_EN
   logic                     err_o;

   modport master (output v_i, data_i, sel_one_hot_i, yumi_i,
                   input  ready_o, v_o, data_o, err_o);
   modport slave  (input  v_i, data_i, sel_one_hot_i, yumi_i,
                   output ready_o, v_o, data_o, err_o);
`else
   modport master (output v_i, data_i, sel_one_hot_i, yumi_i,
                   input  ready_o, v_o, data_o);
   modport slave  (input  v_i, data_i, sel_one_hot_i, yumi_i,
                   output ready_o, v_o, data_o);
`endif
endinterface

// File: rtl/bsg_demux_one_hot_slot.sv
// One-entry lane buffer: holds a word from enqueue until the consumer yumis it.
module bsg_demux_one_hot_slot #(
   parameter int width_p = 9
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               enq_i,
   input  logic [width_p-1:0] data_i,
   input  logic               yumi_i,
   output logic               full_o,
   output logic [width_p-1:0] data_o
);
   logic               full_r;
   logic [width_p-1:0] data_r;

   // Enqueue wins over yumi so a same-cycle refill keeps the lane full.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         full_r <= 1'b0;
         data_r <= '0;
      end else if (enq_i) begin
         full_r <= 1'b1;
         data_r <= data_i;
      end else if (yumi_i) begin
         full_r <= 1'b0;
         data_r <= data_r;
      end else begin
         full_r <= full_r;
         data_r <= data_r;
      end
   end

   assign full_o = full_r;
   assign data_o = data_r;
endmodule

// File: rtl/bsg_demux_one_hot_buffered.sv
// Steers one input word to a one-hot selected lane, each lane a one-entry buffer.
// Optional select checking and sticky err_o: BSG_DEMUX_ONE_HOT_SEL_CHECK_EN.
module bsg_demux_one_hot_buffered
   import bsg_demux_one_hot_pkg::*;
#(
   parameter int width_p = width_default_lp,
   parameter int els_p   = els_default_lp
) (
   input logic clk_i,
   input logic reset_i,
   bsg_demux_one_hot_buffered_if.slave bus
);
   logic [els_p-1:0]         full_s;
   logic [els_p-1:0]         can_take_s;
   logic [els_p-1:0]         enq_s;
   logic                     accept_s;
   logic [width_p-1:0]       slot_data_s [els_p];
   logic [els_p*width_p-1:0] data_packed_s;

   // A lane can accept when empty or when its consumer is draining it now.
   assign can_take_s = ~full_s | bus.yumi_i;

`ifdef BSG_DEMUX_ONE_HOT_SEL_CHECK_EN
   logic illegal_sel_s;
   logic err_r;

   assign illegal_sel_s = bus.v_i & ~is_one_hot(sel_max_lp'(bus.sel_one_hot_i));
   assign bus.ready_o   = (|(bus.sel_one_hot_i & can_take_s)) | illegal_sel_s;
   assign accept_s      = bus.v_i & bus.ready_o & ~illegal_sel_s;

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_r <= 1'b0;
      end else if (illegal_sel_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign bus.err_o = err_r;
`else
   assign bus.ready_o = |(bus.sel_one_hot_i & can_take_s);
   assign accept_s    = bus.v_i & bus.ready_o;
`endif

   assign enq_s = {els_p{accept_s}} & bus.sel_one_hot_i & can_take_s;

   for (genvar k = 0; k < els_p; k++) begin : g_slot
      bsg_demux_one_hot_slot #(.width_p(width_p)) slot (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .enq_i   (enq_s[k]),
         .data_i  (bus.data_i),
         .yumi_i  (bus.yumi_i[k]),
         .full_o  (full_s[k]),
         .data_o  (slot_data_s[k])
      );
   end

   // Lane k occupies data_o[k*width_p +: width_p].
   always_comb begin
      data_packed_s = '0;
      for (int k = 0; k < els_p; k++) begin
         data_packed_s[k*width_p +: width_p] = slot_data_s[k];
      end
   end

   assign bus.v_o    = full_s;
   assign bus.data_o = data_packed_s;
endmodule
